// File: rtl/suprloco_video_timing.sv
// rtl/suprloco_video_timing.sv - pixel clock enable, raster counters and re-timed blanked video output
//
// Purpose:
//   Divides the 40 MHz master clock into a 1-in-8 pixel clock enable, runs the
//   H/V raster counters that drive the layer/palette fetch pipeline, and
//   re-times the palette RGB into blanked video. Enable and sync are delayed
//   to line up with the RGB coming back from the pipeline.
//
// Ports:
//   i_EMU_MCLK     master clock (only clock)
//   i_EMU_SRST     synchronous active-high reset
//   o_VIDEO_CEN    pixel clock enable, one MCLK in eight
//   o_HCOUNT       horizontal raster count to the fetch pipeline
//   o_VCOUNT       vertical raster count to the fetch pipeline
//   o_HBLANK       undelayed horizontal blank
//   o_VBLANK       undelayed vertical blank
//   o_FRAME_START  high for the CEN period at hcount=0, vcount=0
//   i_PIXEL_RGB    {R,G,B} from the palette, PIPE_DELAY CENs behind its counters
//   o_VIDEO_EN     delayed active-video flag
//   o_VIDEO_R/G/B  blanked colour components
//   o_HSYNC_n      delayed active-low hsync
//   o_VSYNC_n      delayed active-low vsync
//   i_FLIP         screen flip request (only with SUPRLOCO_FLIPSCREEN_EN)
//
// Build option:
//   SUPRLOCO_FLIPSCREEN_EN - adds i_FLIP; mirrors the published counters.

module suprloco_video_timing #(
  parameter int HTOTAL      = 320,
  parameter int HACTIVE     = 256,
  parameter int HSYNC_START = 280,
  parameter int HSYNC_LEN   = 24,
  parameter int VTOTAL      = 262,
  parameter int VACTIVE     = 224,
  parameter int VSYNC_START = 234,
  parameter int VSYNC_LEN   = 3,
  parameter int PIPE_DELAY  = 3
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_SRST,
`ifdef SUPRLOCO_FLIPSCREEN_EN
  input  logic       i_FLIP,
`endif
  output logic       o_VIDEO_CEN,
  output logic [8:0] o_HCOUNT,
  output logic [8:0] o_VCOUNT,
  output logic       o_HBLANK,
  output logic       o_VBLANK,
  output logic       o_FRAME_START,
  input  logic [8:0] i_PIXEL_RGB,
  output logic       o_VIDEO_EN,
  output logic [2:0] o_VIDEO_R,
  output logic [2:0] o_VIDEO_G,
  output logic [2:0] o_VIDEO_B,
  output logic       o_HSYNC_n,
  output logic       o_VSYNC_n
);

  generate
    if (HTOTAL > 512 || VTOTAL > 512 || HACTIVE < 1 || VACTIVE < 1 ||
        HACTIVE >= HTOTAL || VACTIVE >= VTOTAL ||
        HSYNC_LEN < 1 || VSYNC_LEN < 1 ||
        HSYNC_START + HSYNC_LEN > HTOTAL || VSYNC_START + VSYNC_LEN > VTOTAL ||
        PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_params
      $error("suprloco_video_timing: raster parameters out of range");
    end
  endgenerate

  // Comparisons are done on 10 bits so a sync window ending at 512 still fits.
  localparam logic [9:0] H_TOTAL_M1 = 10'(HTOTAL - 1);
  localparam logic [9:0] H_ACTIVE   = 10'(HACTIVE);
  localparam logic [9:0] HS_START   = 10'(HSYNC_START);
  localparam logic [9:0] HS_END     = 10'(HSYNC_START + HSYNC_LEN);
  localparam logic [9:0] V_TOTAL_M1 = 10'(VTOTAL - 1);
  localparam logic [9:0] V_ACTIVE   = 10'(VACTIVE);
  localparam logic [9:0] VS_START   = 10'(VSYNC_START);
  localparam logic [9:0] VS_END     = 10'(VSYNC_START + VSYNC_LEN);
  localparam logic [8:0] H_RESET    = 9'(HACTIVE);
  localparam logic [8:0] V_RESET    = 9'(VTOTAL - 1);

  logic [2:0] div_q;
  logic       cen;
  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic [9:0] h_ext, v_ext;
  logic       h_act, v_act, active, hsync, vsync;
  logic [2:0] dly_q [PIPE_DELAY];
  logic [2:0] dly_out;
  logic       video_en_q;
  logic [8:0] rgb_q;
  logic       hsync_n_q, vsync_n_q;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SRST) div_q <= 3'd0;
    else            div_q <= div_q + 3'd1;
  end

  assign cen = (div_q == 3'd7);

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (cen) begin
      if ({1'b0, hcount_q} == H_TOTAL_M1) begin
        hcount_d = 9'd0;
        if ({1'b0, vcount_q} == V_TOTAL_M1) vcount_d = 9'd0;
        else                                 vcount_d = vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
    end
  end

  // Counters come out of reset in the last line's blanking so the first
  // visible pixel after reset is line 0, pixel 0.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SRST) begin
      hcount_q <= H_RESET;
      vcount_q <= V_RESET;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign h_ext  = {1'b0, hcount_q};
  assign v_ext  = {1'b0, vcount_q};
  assign h_act  = (h_ext < H_ACTIVE);
  assign v_act  = (v_ext < V_ACTIVE);
  assign active = h_act && v_act;
  assign hsync  = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vsync  = (v_ext >= VS_START) && (v_ext < VS_END);

  // Delay line matches enable/sync to the palette pipeline latency.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SRST) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b000;
    end else if (cen) begin
      dly_q[0] <= {active, hsync, vsync};
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly_out = dly_q[PIPE_DELAY-1];

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SRST) begin
      video_en_q <= 1'b0;
      rgb_q      <= 9'd0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
    end else if (cen) begin
      video_en_q <= dly_out[2];
      rgb_q      <= dly_out[2] ? i_PIXEL_RGB : 9'd0;
      hsync_n_q  <= ~dly_out[1];
      vsync_n_q  <= ~dly_out[0];
    end
  end

`ifdef SUPRLOCO_FLIPSCREEN_EN
  localparam logic [8:0] H_ACT_M1 = 9'(HACTIVE - 1);
  localparam logic [8:0] V_ACT_M1 = 9'(VACTIVE - 1);
  logic flip_q;

  // Latched on the edge that enters the frame-start period, so the flip
  // already applies to pixel 0 of line 0 and never changes mid-frame.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_SRST)                                       flip_q <= 1'b0;
    else if (cen && hcount_d == 9'd0 && vcount_d == 9'd0) flip_q <= i_FLIP;
  end

  always_comb begin
    o_HCOUNT = hcount_q;
    o_VCOUNT = vcount_q;
    if (flip_q && active) o_HCOUNT = H_ACT_M1 - hcount_q;
    if (flip_q && v_act)  o_VCOUNT = V_ACT_M1 - vcount_q;
  end
`else
  assign o_HCOUNT = hcount_q;
  assign o_VCOUNT = vcount_q;
`endif

  assign o_VIDEO_CEN   = cen;
  assign o_HBLANK      = ~h_act;
  assign o_VBLANK      = ~v_act;
  assign o_FRAME_START = (hcount_q == 9'd0) && (vcount_q == 9'd0);
  assign o_VIDEO_EN    = video_en_q;
  assign o_VIDEO_R     = rgb_q[8:6];
  assign o_VIDEO_G     = rgb_q[5:3];
  assign o_VIDEO_B     = rgb_q[2:0];
  assign o_HSYNC_n     = hsync_n_q;
  assign o_VSYNC_n     = vsync_n_q;

endmodule

// File: tb/tb_suprloco_video_timing.sv
// tb/tb_suprloco_video_timing.sv - directed self-checking bench for suprloco_video_timing

module tb_suprloco_video_timing;

  localparam int HT  = 44;
  localparam int HA  = 24;
  localparam int HSS = 28;
  localparam int HSL = 5;
  localparam int VT  = 14;
  localparam int VA  = 10;
  localparam int VSS = 11;
  localparam int VSL = 2;
  localparam int PD  = 3;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       srst;
  logic [8:0] pix_in;
  logic       cen, hblank, vblank, fstart, ven, hs_n, vs_n;
  logic [8:0] hcnt, vcnt;
  logic [2:0] r, g, b;
  logic [8:0] rgb;

  int checks = 0;
  int failures = 0;

  int mh, mv;
  bit p_act [0:PD];
  bit p_hs  [0:PD];
  bit p_vs  [0:PD];
  logic [8:0] p_pix [0:PD];
  bit exp_en, exp_hs_n, exp_vs_n;
  logic [8:0] exp_rgb;

  suprloco_video_timing #(
    .HTOTAL(HT), .HACTIVE(HA), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
    .VTOTAL(VT), .VACTIVE(VA), .VSYNC_START(VSS), .VSYNC_LEN(VSL),
    .PIPE_DELAY(PD)
  ) dut (
    .i_EMU_MCLK(clk), .i_EMU_SRST(srst),
    .o_VIDEO_CEN(cen), .o_HCOUNT(hcnt), .o_VCOUNT(vcnt),
    .o_HBLANK(hblank), .o_VBLANK(vblank), .o_FRAME_START(fstart),
    .i_PIXEL_RGB(pix_in), .o_VIDEO_EN(ven),
    .o_VIDEO_R(r), .o_VIDEO_G(g), .o_VIDEO_B(b),
    .o_HSYNC_n(hs_n), .o_VSYNC_n(vs_n)
  );

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  function automatic logic [8:0] pix(input int h, input int v);
    logic [3:0] vv;
    logic [4:0] hh;
    vv = v[3:0];
    hh = h[4:0];
    return {vv, hh};
  endfunction

  task automatic model_reset();
    mh = HA;
    mv = VT - 1;
    for (int i = 0; i <= PD; i++) begin
      p_act[i] = 0; p_hs[i] = 0; p_vs[i] = 0; p_pix[i] = 9'd0;
    end
    exp_en = 0; exp_rgb = 9'd0; exp_hs_n = 1; exp_vs_n = 1;
    pix_in = 9'h1FF;
  endtask

  // Called at the sampling point of a CEN period, before the CEN edge.
  task automatic advance_model();
    for (int i = PD; i > 0; i--) begin
      p_act[i] = p_act[i-1]; p_hs[i] = p_hs[i-1];
      p_vs[i]  = p_vs[i-1];  p_pix[i] = p_pix[i-1];
    end
    p_act[0] = (mh < HA) && (mv < VA);
    p_hs[0]  = (mh >= HSS) && (mh < HSS + HSL);
    p_vs[0]  = (mv >= VSS) && (mv < VSS + VSL);
    p_pix[0] = pix(mh, mv);
    pix_in   = p_act[PD] ? p_pix[PD] : 9'h1FF;
    exp_en   = p_act[PD];
    exp_rgb  = p_act[PD] ? p_pix[PD] : 9'd0;
    exp_hs_n = !p_hs[PD];
    exp_vs_n = !p_vs[PD];
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic wait_cen(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cen && n < 16);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (hcnt !== 9'(HA)) begin failures++; $display("FAIL reset_hcount got=%0d exp=%0d", hcnt, HA); end
    checks++; if (vcnt !== 9'(VT-1)) begin failures++; $display("FAIL reset_vcount got=%0d exp=%0d", vcnt, VT-1); end
    checks++; if (ven !== 1'b0) begin failures++; $display("FAIL reset_video_en got=%b exp=0", ven); end
    checks++; if (rgb !== 9'd0) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    checks++; if (hs_n !== 1'b1 || vs_n !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b%b exp=11", hs_n, vs_n); end
    checks++; if (fstart !== 1'b0 || cen !== 1'b0) begin failures++; $display("FAIL reset_fs_cen got=%b%b exp=00", fstart, cen); end
    srst = 1'b0;
  endtask

  task automatic test_cen_cadence();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i < 7) begin
        checks++; if (cen !== 1'b0) begin failures++; $display("FAIL cen_early mclk=%0d got=%b exp=0", i, cen); end
      end else begin
        checks++; if (cen !== 1'b1) begin failures++; $display("FAIL cen_first mclk=%0d got=%b exp=1", i, cen); end
      end
      checks++; if (ven !== 1'b0 || rgb !== 9'd0 || hs_n !== 1'b1 || vs_n !== 1'b1) begin
        failures++; $display("FAIL cen_outputs_held mclk=%0d got=%b/%h/%b%b exp=0/000/11", i, ven, rgb, hs_n, vs_n);
      end
    end
    checks++; if (hcnt !== 9'(HA) || vcnt !== 9'(VT-1)) begin
      failures++; $display("FAIL cen_first_counts got=%0d,%0d exp=%0d,%0d", hcnt, vcnt, HA, VT-1);
    end
    advance_model();
  endtask

  task automatic test_two_frames();
    int n;
    int en_cnt = 0, fs_cnt = 0, lines = 0, vs_low = 0;
    int en_run = 0, hs_run = 0;
    bit prev_en = 0, prev_hs_n = 1;
    for (int k = 1; k <= 2 * FRAME + 19; k++) begin
      wait_cen(n);
      checks++; if (n !== 8) begin failures++; $display("FAIL cen_period k=%0d got=%0d exp=8", k, n); end
      checks++; if (hcnt !== 9'(mh) || vcnt !== 9'(mv)) begin
        failures++; $display("FAIL counters k=%0d got=%0d,%0d exp=%0d,%0d", k, hcnt, vcnt, mh, mv);
      end
      checks++; if (hblank !== (mh >= HA) || vblank !== (mv >= VA)) begin
        failures++; $display("FAIL blank k=%0d got=%b%b exp=%b%b", k, hblank, vblank, mh >= HA, mv >= VA);
      end
      checks++; if (fstart !== (mh == 0 && mv == 0)) begin
        failures++; $display("FAIL frame_start k=%0d got=%b exp=%b", k, fstart, mh == 0 && mv == 0);
      end
      checks++; if (ven !== exp_en) begin failures++; $display("FAIL video_en k=%0d got=%b exp=%b", k, ven, exp_en); end
      checks++; if (rgb !== exp_rgb) begin failures++; $display("FAIL rgb k=%0d got=%h exp=%h", k, rgb, exp_rgb); end
      checks++; if (hs_n !== exp_hs_n || vs_n !== exp_vs_n) begin
        failures++; $display("FAIL sync k=%0d got=%b%b exp=%b%b", k, hs_n, vs_n, exp_hs_n, exp_vs_n);
      end
      if (ven) begin en_cnt++; en_run++; end
      if (fstart) fs_cnt++;
      if (!vs_n) vs_low++;
      if (prev_en && !ven) begin
        lines++;
        checks++; if (en_run !== HA) begin failures++; $display("FAIL line_length k=%0d got=%0d exp=%0d", k, en_run, HA); end
        en_run = 0;
      end
      if (!hs_n) hs_run++;
      if (!prev_hs_n && hs_n) begin
        checks++; if (hs_run !== HSL) begin failures++; $display("FAIL hsync_width k=%0d got=%0d exp=%0d", k, hs_run, HSL); end
        hs_run = 0;
      end
      prev_en = ven;
      prev_hs_n = hs_n;
      advance_model();
    end
    checks++; if (en_cnt !== 2 * VA * HA) begin failures++; $display("FAIL enable_total got=%0d exp=%0d", en_cnt, 2 * VA * HA); end
    checks++; if (lines !== 2 * VA) begin failures++; $display("FAIL visible_lines got=%0d exp=%0d", lines, 2 * VA); end
    checks++; if (fs_cnt !== 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    checks++; if (vs_low !== 2 * VSL * HT) begin failures++; $display("FAIL vsync_total got=%0d exp=%0d", vs_low, 2 * VSL * HT); end
  endtask

  task automatic test_midline_reset();
    int n;
    int guard = 0;
    bit seen = 0;
    wait_cen(n);
    while (!(mh == 10 && mv == 5) && guard < 2 * FRAME) begin
      advance_model();
      wait_cen(n);
      guard++;
    end
    checks++; if (mh !== 10 || mv !== 5) begin failures++; $display("FAIL midline_reach got=%0d,%0d exp=10,5", mh, mv); end
    checks++; if (ven !== 1'b1 || rgb !== exp_rgb) begin
      failures++; $display("FAIL midline_before got=%b/%h exp=1/%h", ven, rgb, exp_rgb);
    end
    advance_model();
    repeat (3) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    checks++; if (hcnt !== 9'(HA) || vcnt !== 9'(VT-1)) begin
      failures++; $display("FAIL midline_counts got=%0d,%0d exp=%0d,%0d", hcnt, vcnt, HA, VT-1);
    end
    checks++; if (ven !== 1'b0 || rgb !== 9'd0 || hs_n !== 1'b1 || vs_n !== 1'b1) begin
      failures++; $display("FAIL midline_outputs got=%b/%h/%b%b exp=0/000/11", ven, rgb, hs_n, vs_n);
    end
    srst = 1'b0;
    model_reset();
    for (int k = 0; k <= 40; k++) begin
      wait_cen(n);
      checks++; if (n !== ((k == 0) ? 7 : 8)) begin failures++; $display("FAIL post_reset_cen k=%0d got=%0d", k, n); end
      checks++; if (ven !== exp_en || rgb !== exp_rgb) begin
        failures++; $display("FAIL post_reset_video k=%0d got=%b/%h exp=%b/%h", k, ven, rgb, exp_en, exp_rgb);
      end
      if (ven && !seen) begin
        seen = 1;
        checks++; if (k !== HT - HA + PD + 1) begin failures++; $display("FAIL first_pixel_time got=%0d exp=%0d", k, HT - HA + PD + 1); end
        checks++; if (rgb !== pix(0, 0)) begin failures++; $display("FAIL first_pixel_value got=%h exp=%h", rgb, pix(0, 0)); end
      end
      advance_model();
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL first_pixel_seen got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_cen_cadence();
    test_two_frames();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
